// File: rtl/contador_pulsos_if.sv
// Bus for the pulse counter front end: raw pulse and controls in, registered count and flags out.
interface contador_pulsos_if;
  logic       Pulso;
  logic       Habilitar;
  logic       Limpiar;
  logic [4:0] Cuenta;
  logic       Pulso_Valido;
  logic       Lleno;
  logic       Desborde;

  modport master (
    output Pulso, Habilitar, Limpiar,
    input  Cuenta, Pulso_Valido, Lleno, Desborde
  );

  modport slave (
    input  Pulso, Habilitar, Limpiar,
    output Cuenta, Pulso_Valido, Lleno, Desborde
  );
endinterface

// File: rtl/contador_pulsos.sv
// Pulse counter front end: 2-flop synchroniser, debouncer, rising-edge counter 0..MAX_COUNT.
// Define CONTADOR_SATURA_EN to saturate at MAX_COUNT; the default build wraps to 0.
module contador_pulsos #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_COUNT       = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  contador_pulsos_if.slave     bus
);

  localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]      CUENTA_MAX = 5'(MAX_COUNT);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             estable_q, estable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       cuenta_q, cuenta_d;
  logic             pulso_valido_q, pulso_valido_d;
  logic             lleno_q, lleno_d;
  logic             desborde_q, desborde_d;
  logic             flanco;

  // Value taken by the count when an edge arrives at the top of the range.
  function automatic logic [4:0] cuenta_en_tope(input logic [4:0] actual);
`ifdef CONTADOR_SATURA_EN
    return actual;
`else
    return (actual == '0) ? 5'd0 : 5'd0;
`endif
  endfunction

  always_comb begin
    s1_d           = bus.Pulso;
    s2_d           = s1_q;
    estable_d      = estable_q;
    cnt_d          = '0;
    cuenta_d       = cuenta_q;
    pulso_valido_d = 1'b0;
    desborde_d     = 1'b0;
    flanco         = 1'b0;

    if (s2_q != estable_q) begin
      if (cnt_q == CNT_LAST) begin
        estable_d = ~estable_q;
        flanco    = ~estable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Clear wins over everything, including a coincident accepted edge.
    if (bus.Limpiar) begin
      cuenta_d = '0;
    end else if (flanco && bus.Habilitar) begin
      pulso_valido_d = 1'b1;
      if (cuenta_q < CUENTA_MAX) begin
        cuenta_d = cuenta_q + 5'd1;
      end else begin
        desborde_d = 1'b1;
        cuenta_d   = cuenta_en_tope(cuenta_q);
      end
    end

    lleno_d = (cuenta_d == CUENTA_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      estable_q      <= 1'b0;
      cnt_q          <= '0;
      cuenta_q       <= '0;
      pulso_valido_q <= 1'b0;
      lleno_q        <= 1'b0;
      desborde_q     <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      estable_q      <= estable_d;
      cnt_q          <= cnt_d;
      cuenta_q       <= cuenta_d;
      pulso_valido_q <= pulso_valido_d;
      lleno_q        <= lleno_d;
      desborde_q     <= desborde_d;
    end
  end

  assign bus.Cuenta       = cuenta_q;
  assign bus.Pulso_Valido = pulso_valido_q;
  assign bus.Lleno        = lleno_q;
  assign bus.Desborde     = desborde_q;

endmodule

// File: doc/contador_pulsos.md
# contador_pulsos

Pulse-counting front end for the pulse counter design. Takes the raw, bouncing pulse input, synchronises and debounces it, and detects accepted rising edges. Counts those edges into a 5-bit binary value in the range 0..MAX_COUNT. `Cuenta` feeds the BCD translation stage directly downstream, which is defined for 0–20.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive cycles the synchronised input must differ from the stable level before the stable level flips. Legal values are ≥2.
- `MAX_COUNT`, default 20: highest value `Cuenta` can reach. Legal values are 1..20.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `Pulso`  in  1: raw asynchronous pulse/button input.
- `Habilitar`  in  1: count enable.
  - Low means accepted edges do not change `Cuenta`.
  - The debouncer keeps tracking the input regardless.
- `Limpiar`  in  1: synchronous clear of the count.
- `Cuenta`  out  5: current count, registered.
- `Pulso_Valido`  out  1: one-cycle strobe for each counted rising edge.
- `Lleno`  out  1: high while `Cuenta == MAX_COUNT`.
- `Desborde`  out  1: one-cycle strobe when an edge is counted while `Cuenta == MAX_COUNT`.

## Operation
- **Synchroniser:** two flops `s1` → `s2`, both reset to 0.
- **Debouncer:**
  - State: stable level `estable` (reset 0) and counter `cnt` (width `$clog2(DEBOUNCE_CYCLES)`, reset 0).
  - On each edge where `s2 != estable`:
    - if `cnt == DEBOUNCE_CYCLES-1`, then `estable` flips and `cnt` goes to 0;
    - otherwise `cnt` increments.
  - On any edge where `s2 == estable`, `cnt` goes to 0. Glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- **Accepted rising edge:** the edge on which `estable` goes 0→1. Falling transitions are debounced identically but never counted.
- **Count update on an accepted rising edge, in priority order:**
  1. `Limpiar`=1: `Cuenta` goes to 0; `Pulso_Valido`=0 and `Desborde`=0. The edge is discarded.
  2. `Habilitar`=0: no change; no strobes.
  3. `Cuenta < MAX_COUNT`: `Cuenta` increments and `Pulso_Valido`=1.
  4. `Cuenta == MAX_COUNT`: `Pulso_Valido`=1 and `Desborde`=1; the next value depends on configuration.
- `Limpiar` without an accepted edge sets `Cuenta` to 0. `Limpiar` never disturbs the synchroniser or debouncer state.
- `Lleno` is registered and tracks the updated `Cuenta` in the same cycle.
- `Cuenta` never leaves 0..MAX_COUNT.

## Timing
- **Reset (`rst_n`=0 at an edge):** `Cuenta`=0, `Pulso_Valido`=0, `Lleno`=0, `Desborde`=0, `s1`=`s2`=0, `estable`=0, `cnt`=0. This applies mid-operation too, including a half-debounced pulse.
- **Pulse held high at reset release:** it is counted normally after the debounce delay.
- **Latency:** `Pulso` rises before edge 1 and stays high. `s2` goes high after edge 2. The mismatch is seen at edges 3…; `estable` flips, `Cuenta` updates and the strobes assert after edge `DEBOUNCE_CYCLES+2`.
- **Strobe width:** strobes are high for exactly one cycle and deassert on the following edge.
- **Minimum countable pulse:** high for ≥`DEBOUNCE_CYCLES` cycles, then low for ≥`DEBOUNCE_CYCLES` cycles before the next pulse.
- **`Habilitar`/`Limpiar`:** sampled on the same edge as the accepted rising edge; no pipelining.

## Configuration
- Macro: `CONTADOR_SATURA_EN`.
- **Defined:** at `Cuenta == MAX_COUNT`, an accepted edge leaves `Cuenta` at MAX_COUNT, and `Lleno` stays 1.
- **Undefined (default):** at `Cuenta == MAX_COUNT`, an accepted edge wraps `Cuenta` to 0, and `Lleno` drops to 0.
- **Both modes:** `Desborde` and `Pulso_Valido` pulse on that edge.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `MAX_COUNT`=20.
- **Reset:** hold `rst_n`=0 for 3 cycles with `Pulso`=1, then release with `Pulso` held at 1.
  - During reset: all outputs 0.
  - After release: `Cuenta`=1 and `Pulso_Valido`=1 for one cycle, 6 edges after release.
- **Clean pulse:** `Pulso` high 10 cycles, low 10 cycles, starting from `Cuenta`=0.
  - `Cuenta` becomes 1 after edge 6 of the high phase.
  - `Pulso_Valido` is high for exactly one cycle.
  - The falling edge causes no strobe.
- **Glitch and bounce:**
  - A 3-cycle high pulse leaves `Cuenta` unchanged.
  - 8 cycles of 1-cycle toggling followed by a steady high give exactly one increment.
- **Overflow:** 21 clean pulses.
  - After pulse 20: `Cuenta`=20, `Lleno`=1.
  - Pulse 21 with the macro undefined: `Cuenta`=0, `Lleno`=0, `Desborde` high for one cycle.
  - Pulse 21 with `CONTADOR_SATURA_EN` defined: `Cuenta`=20, `Lleno`=1, `Desborde` high for one cycle.
- **Clear collision:** with `Cuenta`=7, assert `Limpiar` on the accepted-edge cycle.
  - `Cuenta`=0, with no `Pulso_Valido` and no `Desborde`.
  - The next clean pulse gives `Cuenta`=1.
- **Enable and mid-pulse reset:**
  - With `Habilitar`=0 during 3 clean pulses, `Cuenta` holds at 5 with no strobes.
  - Pulling `rst_n` low 2 cycles into a debounce window clears everything; that pulse is not counted.
